// File: rtl/gate_checker_pkg.sv
// Shared types and constants for the two-input gate truth-table checker.
package gate_checker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  localparam logic [1:0] OP_NOR  = 2'd0;
  localparam logic [1:0] OP_NAND = 2'd1;
  localparam logic [1:0] OP_AND  = 2'd2;
  localparam logic [1:0] OP_OR   = 2'd3;

  localparam int NUM_VECTORS = 4;

endpackage

// File: rtl/gate_checker_if.sv
// Control, result and gate-under-test signals of the gate checker.
interface gate_checker_if;

  logic       start;
  logic [1:0] op;
  logic       drv_a;
  logic       drv_b;
  logic       dut_c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;

  modport master (
    output start, op, dut_c,
    input  drv_a, drv_b, busy, done, pass, fail_vec
  );

  modport slave (
    input  start, op, dut_c,
    output drv_a, drv_b, busy, done, pass, fail_vec
  );

endinterface

// File: rtl/gate_checker_gate_ref.sv
// Combinational reference for the expected output of a two-input gate.
module gate_ref
  import gate_checker_pkg::*;
(
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (op)
      OP_NOR:  y = ~(a | b);
      OP_NAND: y = ~(a & b);
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_checker.sv
// Sweeps all four input vectors through an external gate, waits for it to
// settle, and records which vectors disagree with the expected function.
module gate_checker
  import gate_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input logic           clk,
  input logic           rst_n,
  gate_checker_if.slave bus
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_INDEX  = 2'(NUM_VECTORS - 1);

  state_t     state_q;
  state_t     next_state;
  logic [1:0] index_q;
  logic [7:0] cnt_q;
  logic [1:0] op_q;
  logic       exp_y;
  logic       last_vec;
  logic [3:0] fail_vec_next;

  gate_ref u_gate_ref (
    .op (op_q),
    .a  (index_q[1]),
    .b  (index_q[0]),
    .y  (exp_y)
  );

  assign last_vec = (index_q == LAST_INDEX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= next_state;
  end

  always_comb begin
    next_state    = state_q;
    fail_vec_next = bus.fail_vec;
    case (state_q)
      IDLE:    if (bus.start) next_state = DRIVE;
      DRIVE:   next_state = SETTLE;
      SETTLE:  if (cnt_q == 8'd0) next_state = SAMPLE;
      SAMPLE: begin
        next_state = last_vec ? FINISH : DRIVE;
        if (bus.dut_c != exp_y) fail_vec_next[index_q] = 1'b1;
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q      <= '0;
      cnt_q        <= '0;
      op_q         <= OP_NOR;
      bus.drv_a    <= 1'b0;
      bus.drv_b    <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.pass     <= 1'b0;
      bus.fail_vec <= '0;
    end else begin
      bus.busy <= (next_state != IDLE);
      bus.done <= (next_state == FINISH);
      case (state_q)
        IDLE: if (bus.start) begin
          op_q         <= bus.op;
          index_q      <= '0;
          bus.pass     <= 1'b0;
          bus.fail_vec <= '0;
        end
        DRIVE: begin
          bus.drv_a <= index_q[1];
          bus.drv_b <= index_q[0];
          cnt_q     <= SETTLE_LOAD;
        end
        SETTLE: if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
        SAMPLE: begin
          bus.fail_vec <= fail_vec_next;
          if (last_vec) bus.pass    <= (fail_vec_next == 4'd0);
          else          index_q     <= index_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
